rank_filter_3x3: RTL and testbench

Parametrised 3x3 rank-order filter for streaming grayscale video. It contains its own two-line buffer and window generator and supports a run-time mode: median, minimum (erosion), maximum (dilation) or bypass. It sits in the image-processing chain between colour-space conversion (Y channel) and downstream edge or threshold stages. It supersedes the fixed 8-bit median-only filter: the data width and line length are parametrised, there is per-frame mode selection, border handling is defined, and line-overflow detection is added.

---
 rtl/rank_filter_3x3.sv | 213 +++++++++++++++++++++
 tb/tb_rank_filter_3x3.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_filter_3x3.sv
// rtl/rank_filter_3x3.sv - 3x3 streaming rank-order filter (median/min/max/bypass) with two-line buffer
// Optional feature macro: RANK_FILTER_EDGE_REPLICATE_EN (replicate edge pixels instead of passing borders through)
module rank_filter_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_hsync,
    input  logic              pre_frame_valid,
    input  logic [DATA_W-1:0] pre_img_y,
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_valid,
    output logic [DATA_W-1:0] post_img_y,
    output logic              line_ovf
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic          vsync_d, valid_d, frame_active, col_full;
    logic [AW-1:0] col;
    logic [1:0]    row;
    logic [1:0]    mode_r;
    logic          vs_rise, pix_valid, line_end;

    // A mid-frame reset drops the rest of that frame until the next vsync rise.
    assign vs_rise   = pre_frame_vsync & ~vsync_d;
    assign pix_valid = pre_frame_valid & (frame_active | vs_rise);
    assign line_end  = valid_d & ~pix_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d      <= 1'b0;
            valid_d      <= 1'b0;
            frame_active <= 1'b0;
            col          <= '0;
            col_full     <= 1'b0;
            row          <= 2'd0;
            mode_r       <= 2'd0;
            line_ovf     <= 1'b0;
        end else begin
            vsync_d <= pre_frame_vsync;
            valid_d <= pix_valid;
            if (vs_rise) begin
                frame_active <= 1'b1;
                mode_r       <= mode;
            end
            // col_full marks that address IMG_W-1 has already been written this line.
            if (line_end) begin
                col      <= '0;
                col_full <= 1'b0;
            end else if (pix_valid) begin
                if (col == COL_LAST)
                    col_full <= 1'b1;
                else
                    col <= col + 1'b1;
            end
            if (vs_rise)
                row <= 2'd0;
            else if (line_end && row != 2'd2)
                row <= row + 1'b1;
            if (vs_rise)
                line_ovf <= 1'b0;
            else if (pix_valid && col_full)
                line_ovf <= 1'b1;
        end
    end

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_q, lb1_q;

    assign lb0_q = lb0[col];
    assign lb1_q = lb1[col];

    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            lb0[col] <= lb1_q;
            lb1[col] <= pre_img_y;
        end
    end

    logic [DATA_W-1:0] tap [3];
    logic              border_in, col_load;

`ifdef RANK_FILTER_EDGE_REPLICATE_EN
    // Rows above the frame reuse row 0; column 0 is loaded into all three window columns.
    always_comb begin
        tap[2] = pre_img_y;
        tap[1] = (row == 2'd0) ? pre_img_y : lb1_q;
        tap[0] = (row == 2'd0) ? pre_img_y : ((row == 2'd1) ? lb1_q : lb0_q);
    end
    assign border_in = 1'b0;
    assign col_load  = (col == '0);
`else
    always_comb begin
        tap[2] = pre_img_y;
        tap[1] = lb1_q;
        tap[0] = lb0_q;
    end
    assign border_in = (row != 2'd2) || (col == '0) || (col == AW'(1));
    assign col_load  = 1'b0;
`endif

    logic [DATA_W-1:0] win [3][3];
    logic              s0_valid, s0_border;
    logic [DATA_W-1:0] s1_max [3];
    logic [DATA_W-1:0] s1_mid [3];
    logic [DATA_W-1:0] s1_min [3];
    logic [DATA_W-1:0] s1_p33;
    logic              s1_valid, s1_border;
    logic [DATA_W-1:0] s2_maxmin, s2_midmid, s2_minmax, s2_gmin, s2_gmax, s2_p33;
    logic              s2_valid, s2_border;
    logic [3:0]        vs_dly, hs_dly;
    logic [DATA_W-1:0] sel;

    always_comb begin
        case (mode_r)
            2'd0:    sel = med3(s2_maxmin, s2_midmid, s2_minmax);
            2'd1:    sel = s2_gmin;
            2'd2:    sel = s2_gmax;
            default: sel = s2_p33;
        endcase
        if (s2_border)
            sel = s2_p33;
    end

    // Every stage shifts each cycle so blanking flushes the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
                s1_max[r] <= '0;
                s1_mid[r] <= '0;
                s1_min[r] <= '0;
            end
            s0_valid         <= 1'b0;
            s0_border        <= 1'b0;
            s1_p33           <= '0;
            s1_valid         <= 1'b0;
            s1_border        <= 1'b0;
            s2_maxmin        <= '0;
            s2_midmid        <= '0;
            s2_minmax        <= '0;
            s2_gmin          <= '0;
            s2_gmax          <= '0;
            s2_p33           <= '0;
            s2_valid         <= 1'b0;
            s2_border        <= 1'b0;
            vs_dly           <= 4'd0;
            hs_dly           <= 4'd0;
            post_frame_valid <= 1'b0;
            post_img_y       <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= col_load ? tap[r] : win[r][1];
                win[r][1] <= col_load ? tap[r] : win[r][2];
                win[r][2] <= tap[r];
                s1_max[r] <= max3(win[r][0], win[r][1], win[r][2]);
                s1_mid[r] <= med3(win[r][0], win[r][1], win[r][2]);
                s1_min[r] <= min3(win[r][0], win[r][1], win[r][2]);
            end
            s0_valid         <= pix_valid;
            s0_border        <= border_in;
            s1_p33           <= win[2][2];
            s1_valid         <= s0_valid;
            s1_border        <= s0_border;
            s2_maxmin        <= max3(s1_min[0], s1_min[1], s1_min[2]);
            s2_midmid        <= med3(s1_mid[0], s1_mid[1], s1_mid[2]);
            s2_minmax        <= min3(s1_max[0], s1_max[1], s1_max[2]);
            s2_gmin          <= min3(s1_min[0], s1_min[1], s1_min[2]);
            s2_gmax          <= max3(s1_max[0], s1_max[1], s1_max[2]);
            s2_p33           <= s1_p33;
            s2_valid         <= s1_valid;
            s2_border        <= s1_border;
            vs_dly           <= {vs_dly[2:0], pre_frame_vsync};
            hs_dly           <= {hs_dly[2:0], pre_frame_hsync};
            post_frame_valid <= s2_valid;
            post_img_y       <= s2_valid ? sel : '0;
        end
    end

    assign post_frame_vsync = vs_dly[3];
    assign post_frame_hsync = hs_dly[3];

endmodule

// File: tb/tb_rank_filter_3x3.sv
// tb/tb_rank_filter_3x3.sv - self-checking bench for rank_filter_3x3 against a full-sort window model
module tb_rank_filter_3x3;
    localparam int DW = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          pre_frame_vsync = 1'b0;
    logic          pre_frame_hsync = 1'b0;
    logic          pre_frame_valid = 1'b0;
    logic [DW-1:0] pre_img_y = '0;
    logic          post_frame_vsync, post_frame_hsync, post_frame_valid, line_ovf;
    logic [DW-1:0] post_img_y;

    always #5 clk = ~clk;

    rank_filter_3x3 #(.DATA_W(DW), .IMG_W(IW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .pre_frame_vsync(pre_frame_vsync), .pre_frame_hsync(pre_frame_hsync),
        .pre_frame_valid(pre_frame_valid), .pre_img_y(pre_img_y),
        .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
        .post_frame_valid(post_frame_valid), .post_img_y(post_img_y),
        .line_ovf(line_ovf)
    );

    typedef struct {
        bit v;
        bit vs;
        bit hs;
        int y;
        int r;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   img [8][10];
    int   got [8][10];
    bit   exp_ovf = 1'b0;
    bit   prev_vs = 1'b0;
    int   line_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: gather the 3x3 neighbourhood ending at (r,c), sort all nine, pick by rank.
    function automatic int model_px(int r, int c, int md);
        int vals[$];
        int rr, cc;
        if (md == 3) return img[r][c];
`ifndef RANK_FILTER_EDGE_REPLICATE_EN
        if (r < 2 || c < 2) return img[r][c];
`endif
        for (int dr = -2; dr <= 0; dr++) begin
            for (int dc = -2; dc <= 0; dc++) begin
                rr = (r + dr < 0) ? 0 : r + dr;
                cc = (c + dc < 0) ? 0 : c + dc;
                vals.push_back(img[rr][cc]);
            end
        end
        vals.sort();
        case (md)
            1:       return vals[0];
            2:       return vals[8];
            default: return vals[4];
        endcase
    endfunction

    function automatic exp_t mk(bit v, bit vs, bit hs, int y, int r, int c);
        exp_t e;
        e.v = v; e.vs = vs; e.hs = hs; e.y = v ? y : 0; e.r = r; e.c = c;
        return e;
    endfunction

    // Called at a negedge: check what is due now, drive the next input, advance one cycle.
    task automatic step(bit vs, bit hs, bit v, int y_in, int exp_y, int r, int c);
        exp_t o;
        o = exp_q.pop_front();
        chk("post_valid", 32'(post_frame_valid), 32'(o.v));
        chk("post_vsync", 32'(post_frame_vsync), 32'(o.vs));
        chk("post_hsync", 32'(post_frame_hsync), 32'(o.hs));
        chk($sformatf("post_y r%0d c%0d", o.r, o.c), 32'(post_img_y), o.y);
        chk("line_ovf", 32'(line_ovf), 32'(exp_ovf));
        if (o.v && o.r >= 0) got[o.r][o.c] = int'(post_img_y);
        pre_frame_vsync = vs;
        pre_frame_hsync = hs;
        pre_frame_valid = v;
        pre_img_y       = DW'(y_in);
        exp_q.push_back(mk(v, vs, hs, exp_y, r, c));
        if (vs && !prev_vs) exp_ovf = 1'b0;
        else if (v && line_cnt >= IW) exp_ovf = 1'b1;
        line_cnt = v ? line_cnt + 1 : 0;
        prev_vs  = vs;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 255)), 0, -1, -1);
    endtask

    task automatic reset_phase(int n, bit keep_valid);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            pre_frame_valid = keep_valid;
            pre_img_y       = DW'($urandom_range(0, 255));
            @(posedge clk);
            @(negedge clk);
            chk("rst post_valid", 32'(post_frame_valid), 32'd0);
            chk("rst post_y", 32'(post_img_y), 32'd0);
            chk("rst post_vsync", 32'(post_frame_vsync), 32'd0);
            chk("rst post_hsync", 32'(post_frame_hsync), 32'd0);
            chk("rst line_ovf", 32'(line_ovf), 32'd0);
        end
        rst = 1'b0;
        pre_frame_vsync = 1'b0;
        pre_frame_hsync = 1'b0;
        pre_frame_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0, -1, -1));
        exp_ovf  = 1'b0;
        prev_vs  = 1'b0;
        line_cnt = 0;
    endtask

    task automatic frame_start(int md);
        mode = 2'(md);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 10; c++) got[r][c] = -1;
        step(1'b1, 1'b0, 1'b0, 0, 0, -1, -1);
        step(1'b1, 1'b0, 1'b0, 0, 0, -1, -1);
        idle(3);
    endtask

    task automatic send_line(int r, int w, int md, int blank);
        for (int c = 0; c < w; c++) step(1'b0, 1'b1, 1'b1, img[r][c], model_px(r, c, md), r, c);
        idle(blank);
    endtask

    task automatic send_frame(int md, int h, int w, int sw_row, int sw_md, int blank);
        frame_start(md);
        for (int r = 0; r < h; r++) begin
            if (r == sw_row) mode = 2'(sw_md);
            send_line(r, w, md, blank);
        end
        idle(6);
    endtask

    task automatic fill_const(int v);
        for (int r = 0; r < 8; r++) for (int c = 0; c < 10; c++) img[r][c] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 10; c++) img[r][c] = 10 * r + c;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 10; c++) img[r][c] = int'($urandom_range(0, 255));
    endtask

    initial begin
        reset_phase(3, 1'b0);

        // Partial frame, then a 3-cycle reset with valid active.
        fill_rand();
        frame_start(0);
        send_line(0, 8, 0, 3);
        send_line(1, 8, 0, 3);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b1, img[2][c], model_px(2, c, 0), 2, c);
        reset_phase(3, 1'b1);
        idle(4);
        fill_const(50);
        send_frame(0, 8, 8, -1, 0, 3);
        chk("post_reset r0c0", 32'(got[0][0]), 32'd50);
        chk("post_reset r3c4", 32'(got[3][4]), 32'd50);
        chk("post_reset r7c7", 32'(got[7][7]), 32'd50);

        // Salt pixel under median.
        fill_const(100);
        img[4][4] = 255;
        send_frame(0, 8, 8, -1, 0, 3);
        chk("salt r4c4", 32'(got[4][4]), 32'd100);
        chk("salt r5c5", 32'(got[5][5]), 32'd100);
        chk("salt r6c6", 32'(got[6][6]), 32'd100);
        chk("salt ovf", 32'(line_ovf), 32'd0);

        fill_ramp();
        send_frame(1, 8, 8, -1, 0, 3);
        chk("ramp_min r4c5", 32'(got[4][5]), 32'd23);
        chk("ramp_min r7c7", 32'(got[7][7]), 32'd55);
        send_frame(2, 8, 8, -1, 0, 3);
        chk("ramp_max r4c5", 32'(got[4][5]), 32'd45);
        send_frame(3, 8, 8, -1, 0, 2);
        chk("ramp_bypass r0c0", 32'(got[0][0]), 32'd0);
        chk("ramp_bypass r3c6", 32'(got[3][6]), 32'd36);

        // Mode input changes mid-frame; only the next vsync picks it up.
        send_frame(0, 8, 8, 4, 2, 3);
        chk("latch f1 r5c5", 32'(got[5][5]), 32'd55 - 32'd11);
        send_frame(2, 8, 8, -1, 0, 3);
        chk("latch f2 r5c5", 32'(got[5][5]), 32'd55);

        send_frame(0, 8, 8, -1, 0, 3);
`ifdef RANK_FILTER_EDGE_REPLICATE_EN
        chk("border r0c0", 32'(got[0][0]), 32'd0);
        chk("border r0c3", 32'(got[0][3]), 32'd2);
        chk("border r1c1", 32'(got[1][1]), 32'd1);
`else
        chk("border r0c3", 32'(got[0][3]), 32'd3);
        chk("border r1c1", 32'(got[1][1]), 32'd11);
`endif

        // 10-pixel line overflows an 8-pixel line buffer.
        fill_rand();
        frame_start(3);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 1'b1, img[0][c], model_px(0, c, 3), 0, c);
            if (c == 7) chk("ovf after 8th", 32'(line_ovf), 32'd0);
            if (c == 8) chk("ovf after 9th", 32'(line_ovf), 32'd1);
        end
        idle(6);
        chk("ovf sticky", 32'(line_ovf), 32'd1);
        step(1'b1, 1'b0, 1'b0, 0, 0, -1, -1);
        chk("ovf cleared", 32'(line_ovf), 32'd0);
        step(1'b1, 1'b0, 1'b0, 0, 0, -1, -1);
        idle(4);

        for (int f = 0; f < 6; f++) begin
            fill_rand();
            send_frame(int'($urandom_range(0, 3)), int'($urandom_range(3, 8)), int'($urandom_range(3, 8)),
                       -1, 0, int'($urandom_range(1, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
